nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
Multi-cycle controller that adds two WIDTH-bit operands using the team's existing adder4bit slice (4-bit a/b/cin in, 4-bit sum/cout out), one nibble per clock, LSB nibble first.
- Latches operands on a start request, steps a nibble index, and registers the inter-nibble carry.
- Presents the full-width result with a one-cycle done pulse.
- Used where a wide add is needed but only one 4-bit adder slice is budgeted.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived number of adder4bit passes; not overridden independently.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin an add; sampled only in IDLE
- a  input  WIDTH  operand A; captured at accepted start
- b  input  WIDTH  operand B; captured at accepted start
- cin  input  1  carry-in to nibble 0; captured at accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse: sum/cout are valid and newly updated
- sum  output  WIDTH  result register
- cout  output  1  carry out of the most significant nibble

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE, idx=0, carry reg=0, operand regs=0, sum=0, cout=0, done=0, busy=0. This applies mid-RUN: the partial result is discarded and sum/cout read 0.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE: on a clk edge with start=1:
  - latch a, b and cin (cin goes into the carry reg)
  - idx=0, state goes to RUN
  - With start=0, stay in IDLE.
- RUN: each edge drives the adder4bit slice with:
  - a_reg[4*idx+3:4*idx], b_reg[4*idx+3:4*idx], carry reg
  - The slice sum is written into the internal accumulator nibble idx.
  - The slice cout is written into the carry reg.
  - idx increments.
- RUN exit: on the edge that processes idx=NIBBLES-1:
  - state goes to DONE
  - sum is loaded from the accumulator, including the nibble being written that edge
  - cout is loaded from the slice cout
  - done goes to 1
- DONE: lasts exactly one cycle. On the next edge, state goes to IDLE and done goes to 0.
- Latency: start sampled at edge E0, done high in the cycle after edge E(NIBBLES). For WIDTH=16, that is 4 cycles after the start edge. Throughput is one add per NIBBLES+2 cycles.
- sum/cout change only at the RUN exit edge or at reset. They hold their value through IDLE and the next RUN, so partial results are never visible on sum.
- start is ignored in RUN and DONE; no queuing. Changes on a, b or cin after capture have no effect on the operation in progress.
- Arithmetic: result is (a + b + cin) mod 2^WIDTH; cout is bit WIDTH of the full sum. A carry ripples across nibbles only through the carry reg, one nibble per cycle.
- idx width is clog2(NIBBLES), minimum 1 bit; it never exceeds NIBBLES-1.
- WIDTH=4: RUN lasts one cycle, and the exit and first-nibble edge coincide.

Decomposition:
- Shared package: state encoding constants (S_IDLE=0, S_RUN=1, S_DONE=2) and the NIBBLE_W=4 constant.
- Sub-module: the existing adder4bit, instantiated once. All sequencing, operand slicing and the carry reg live in this block; no other sub-module.

Test Plan:
- 0x0003 + 0x0002, cin=1 -> done 4 cycles after start edge; sum=0x0006, cout=0; busy high for exactly 5 cycles.
- 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1. Checks the carry chain through all four nibbles.
- 0xFFFF + 0xFFFF, cin=1 -> sum=0xFFFF, cout=1. Then 0x000C + 0x0001, cin=0 -> sum=0x000D, cout=0. Checks that the carry reg is reloaded from the new cin and not left stale.
- Start 0x1234 + 0x1111 (cin=0). One cycle later, drive start=1 with a=0xFFFF and change b to 0x0000 -> ignored; result sum=0x2345, cout=0. Exactly one done pulse.
- After a completed 0x0005 + 0x0007 (cin=1, sum=0x000D), start 0x00F0 + 0x0010. Pulse rst_n low during the 2nd RUN cycle -> busy/done/sum/cout=0 immediately. After release, 0x0004 + 0x0006, cin=1 -> sum=0x000B.
- Back-to-back: hold start=1 continuously -> a new add is accepted every 6 cycles (IDLE, 4×RUN, DONE). Each done pulse is one cycle and matches its captured operands.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants for the nibble-serial adder: FSM state encoding and slice width.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_adder_adder4bit.sv
// 4-bit ripple adder slice: {cout, sum} = a + b + cin.
module adder4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder built from a single adder4bit slice, one nibble per clock, LSB first.
// The inter-nibble carry lives in carry_q; the result appears only at RUN exit.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef logic [NIBBLES-1:0][NIBBLE_W-1:0] nib_vec_t;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    nib_vec_t         a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;

    adder4bit u_slice (
        .a   (a_q[idx_q]),
        .b   (b_q[idx_q]),
        .cin (carry_q),
        .sum (slice_sum),
        .cout(slice_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d[idx_q] = slice_sum;
                carry_d      = slice_cout;
                if (idx_q == LAST_IDX) begin
                    // acc_d already holds the top nibble written this edge
                    sum_d   = acc_d;
                    cout_d  = slice_cout;
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed + random checks of nibble_serial_adder (WIDTH=16) against an arithmetic model.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int errors = 0;
    int checks = 0;
    logic [WIDTH:0] last_res;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic c);
        int unsigned total;
        total = int'(x) + int'(y) + int'(c);
        return total[WIDTH:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full transaction: start at E0, expect done after E4, idle after E5.
    task automatic do_add(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tc,
                          input string tag);
        logic [WIDTH:0] exp;
        int n;
        int busy_cnt;
        exp = ref_add(ta, tb_, tc);
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
        busy_cnt = busy ? 1 : 0;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (busy) busy_cnt++;
            if (!done && n == 2) chk({tag, " hold"}, 32'({cout, sum}), 32'(last_res));
        end
        chk({tag, " latency"}, n, 4);
        chk({tag, " result"}, 32'({cout, sum}), 32'(exp));
        @(posedge clk); #1;
        chk({tag, " done_drop"}, 32'(done), 0);
        chk({tag, " busy_cycles"}, busy_cnt + (busy ? 1 : 0), 5);
        last_res = exp;
    endtask

    initial begin
        logic [WIDTH:0] exp;
        logic [WIDTH:0] expq[$];
        int pulses;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        last_res = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'({busy, done, cout, sum}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_no_start", 32'({busy, done}), 0);

        do_add(16'h0003, 16'h0002, 1'b1, "small");
        do_add(16'hFFFF, 16'h0001, 1'b0, "ripple");
        do_add(16'hFFFF, 16'hFFFF, 1'b1, "max");
        do_add(16'h000C, 16'h0001, 1'b0, "carry_reload");

        // start and operand changes during RUN/DONE must not disturb the add
        exp = ref_add(16'h1234, 16'h1111, 1'b0);
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'h0000;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                chk("ignore_result", 32'({cout, sum}), 32'(exp));
            end
        end
        start = 1'b0;
        chk("ignore_pulses", pulses, 1);
        chk("ignore_idle", 32'(busy), 0);
        last_res = exp;

        // asynchronous reset in the middle of RUN
        do_add(16'h0005, 16'h0007, 1'b1, "pre_reset");
        @(negedge clk);
        a = 16'h00F0; b = 16'h0010; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset", 32'({busy, done, cout, sum}), 0);
        last_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        do_add(16'h0004, 16'h0006, 1'b1, "post_reset");

        for (int i = 0; i < 6; i++) begin
            do_add(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "random");
        end

        // start held high: accepts at edges 0,6,12,18, done after 4,10,16,22
        for (int t = 0; t < 24; t++) begin
            @(negedge clk);
            a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); start = 1'b1;
            if (t % 6 == 0) expq.push_back(ref_add(a, b, cin));
            @(posedge clk); #1;
            chk("b2b_busy", 32'(busy), 32'(t % 6 != 5));
            if (t % 6 == 4) begin
                chk("b2b_done", 32'(done), 1);
                if (expq.size() > 0) chk("b2b_result", 32'({cout, sum}), 32'(expq.pop_front()));
            end else begin
                chk("b2b_no_done", 32'(done), 0);
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
